// File: rtl/ascii_paste_fifo.sv
// Paced text-paste engine: filters ioctl download bytes into a FIFO and replays them
// one character at a time with per-char / per-line idle gaps and a valid/ready handshake.
module ascii_paste_fifo #(
    parameter int DEPTH_LOG2 = 9,
    parameter int CHAR_GAP   = 50000,
    parameter int LINE_GAP   = 2000000,
    parameter int CNT_W      = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ioctl_download,
    input  logic             ioctl_wr,
    input  logic [7:0]       ioctl_dout,
    output logic             ioctl_wait,
    input  logic [1:0]       lf_mode,
    input  logic             upcase,
    input  logic             abort,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] sent_count
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CW      = DEPTH_LOG2 + 1;
    localparam int GAP_MAX = (LINE_GAP > CHAR_GAP) ? LINE_GAP : CHAR_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [GAP_W-1:0] CHAR_RELOAD = GAP_W'(CHAR_GAP - 1);
    localparam logic [GAP_W-1:0] LINE_RELOAD = GAP_W'(LINE_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

    logic [7:0]            r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_dl_prev;
    logic                  r_last_cr;
    logic                  r_overrun;
    logic [CNT_W-1:0]      r_sent_count;
    state_t                r_state;
    logic [7:0]            r_char_out;
    logic                  r_char_valid;
    logic [GAP_W-1:0]      r_gap;

    logic       w_dl_rise;
    logic       w_last_cr_eff;
    logic [7:0] w_up;
    logic [7:0] w_filt;
    logic       w_keep;
    logic       w_wr;
    logic       w_full;
    logic       w_push;
    logic       w_lost;
    logic       w_pop;
    logic       w_accept;

    assign w_dl_rise     = ioctl_download & ~r_dl_prev;
    // The download-start clear of last_cr must already apply to a byte arriving that cycle.
    assign w_last_cr_eff = r_last_cr & ~w_dl_rise;

    always_comb begin
        w_up = ioctl_dout;
        if (upcase && ioctl_dout >= 8'h61 && ioctl_dout <= 8'h7A)
            w_up = ioctl_dout - 8'h20;
    end

    always_comb begin
        w_filt = w_up;
        w_keep = 1'b1;
        case (lf_mode)
            2'b01:   if (w_up == 8'h0A) w_keep = 1'b0;
            2'b10:   if (w_up == 8'h0A) w_filt = 8'h0D;
            2'b11:   if (w_up == 8'h0A && w_last_cr_eff) w_keep = 1'b0;
            default: ;
        endcase
        if (w_filt == 8'h00)
            w_keep = 1'b0;
    end

    assign w_wr     = ioctl_download & ioctl_wr & ~abort;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_push   = w_wr & w_keep & ~w_full;
    assign w_lost   = w_wr & w_keep & w_full;
    assign w_pop    = (r_state == S_IDLE) & (r_count != '0) & ~abort;
    assign w_accept = (r_state == S_PRESENT) & char_ready & ~abort;

    always_ff @(posedge clk_sys) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_filt;
    end

    always_ff @(posedge clk_sys) begin
        if (reset || abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_prev    <= 1'b0;
            r_last_cr    <= 1'b0;
            r_overrun    <= 1'b0;
            r_sent_count <= '0;
        end else begin
            r_dl_prev <= ioctl_download;
            // last_cr follows the raw received byte, before any filtering.
            if (w_wr)
                r_last_cr <= (ioctl_dout == 8'h0D);
            else if (w_dl_rise)
                r_last_cr <= 1'b0;
            if (w_lost)
                r_overrun <= 1'b1;
            else if (w_dl_rise)
                r_overrun <= 1'b0;
            if (w_dl_rise)
                r_sent_count <= '0;
            else if (w_accept && r_sent_count != '1)
                r_sent_count <= r_sent_count + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_char_out   <= 8'h00;
            r_char_valid <= 1'b0;
            r_gap        <= '0;
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_char_valid <= 1'b0;
            r_gap        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_char_out   <= r_mem[r_rd_ptr];
                        r_char_valid <= 1'b1;
                        r_state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (char_ready) begin
                        r_char_valid <= 1'b0;
                        r_gap        <= (r_char_out == 8'h0D) ? LINE_RELOAD : CHAR_RELOAD;
                        r_state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0)
                        r_state <= S_IDLE;
                    else
                        r_gap <= r_gap - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ioctl_wait = w_full;
    assign char_out   = r_char_out;
    assign char_valid = r_char_valid;
    assign overrun    = r_overrun;
    assign sent_count = r_sent_count;
    assign busy       = ioctl_download | (r_count != '0) | (r_state != S_IDLE);

endmodule
